// File: rtl/nes_pkg.sv
// Shared NES definitions used by the sprite DMA controller.
//   dma_state_t      : sprite DMA sequencer states
//   ADDR_OAMDMA      : CPU write address that starts a sprite DMA
//   ADDR_OAMDATA     : PPU OAMDATA register, target of every DMA write
//   XFER_LEN_DEFAULT : bytes per sprite DMA (one full OAM)
package nes_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } dma_state_t;

  localparam logic [15:0] ADDR_OAMDMA      = 16'h4014;
  localparam logic [15:0] ADDR_OAMDATA     = 16'h2004;
  localparam int unsigned XFER_LEN_DEFAULT = 256;

endpackage

// File: rtl/oam_dma_ctrl.sv
// Sprite (OAM) DMA controller. A CPU write to DMA_REG_ADDR halts the CPU,
// then XFER_LEN bytes are copied from CPU page {data,8'h00} to OAM_DATA_ADDR
// as alternating read/write bus cycles. One clk is one CPU bus cycle.
//   clk        : CPU clock
//   n_reset    : asynchronous active-low reset
//   cpu_addr   : CPU address (meaningful while dma_active=0)
//   cpu_rw     : CPU read/write, 1=read
//   cpu_wdata  : CPU write data (source page on trigger)
//   bus_rdata  : data bus value during DMA read cycles
//   cpu_halt   : stalls the CPU
//   dma_active : DMA owns the bus; top muxes dma_* onto it
//   dma_addr   : DMA bus address
//   dma_rw     : DMA read/write, 1=read
//   dma_wdata  : DMA write data
//   busy       : transfer in progress
module oam_dma_ctrl
  import nes_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = ADDR_OAMDMA,
  parameter logic [15:0] OAM_DATA_ADDR = ADDR_OAMDATA,
  parameter int unsigned XFER_LEN      = XFER_LEN_DEFAULT
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rw,
  input  logic [7:0]  cpu_wdata,
  input  logic [7:0]  bus_rdata,
  output logic        cpu_halt,
  output logic        dma_active,
  output logic [15:0] dma_addr,
  output logic        dma_rw,
  output logic [7:0]  dma_wdata,
  output logic        busy
);

  localparam logic [7:0] IDX_LAST = 8'(XFER_LEN - 1);

  dma_state_t state;
  logic       parity;
  logic [7:0] page;
  logic [7:0] idx;
  logic [7:0] buffer;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state  <= IDLE;
      parity <= 1'b0;
      page   <= '0;
      idx    <= '0;
      buffer <= '0;
    end else begin
      // Free-running get/put phase; never held by the DMA.
      parity <= ~parity;
      case (state)
        IDLE: begin
          if (!cpu_rw && (cpu_addr == DMA_REG_ADDR)) begin
            page  <= cpu_wdata;
            idx   <= '0;
            state <= HALT;
          end
        end
        // An odd halt cycle needs one dummy read to realign onto a get cycle.
        HALT:  state <= parity ? ALIGN : READ;
        ALIGN: state <= READ;
        READ: begin
          buffer <= bus_rdata;
          state  <= WRITE;
        end
        WRITE: begin
          if (idx == IDX_LAST) begin
            idx   <= '0;
            state <= IDLE;
          end else begin
            idx   <= idx + 8'd1;
            state <= READ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    dma_active = 1'b0;
    dma_addr   = '0;
    dma_rw     = 1'b1;
    dma_wdata  = '0;
    case (state)
      ALIGN, READ: begin
        dma_active = 1'b1;
        dma_addr   = {page, idx};
      end
      WRITE: begin
        dma_active = 1'b1;
        dma_rw     = 1'b0;
        dma_addr   = OAM_DATA_ADDR;
        dma_wdata  = buffer;
      end
      default: ;
    endcase
  end

  assign cpu_halt = (state != IDLE);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl: a bus-level reference model predicts
// the full sequence of DMA bus cycles and halt length for each transfer.
module tb_oam_dma_ctrl;

  logic        clk;
  logic        n_reset;
  logic [15:0] cpu_addr;
  logic        cpu_rw;
  logic [7:0]  cpu_wdata;
  logic [7:0]  bus_rdata;
  logic        cpu_halt;
  logic        dma_active;
  logic [15:0] dma_addr;
  logic        dma_rw;
  logic [7:0]  dma_wdata;
  logic        busy;

  int checks;
  int errors;
  int edge_cnt;

  logic [7:0] mem [0:65535];

  typedef struct packed {
    logic [15:0] addr;
    logic        rw;
    logic [7:0]  data;
  } op_t;

  oam_dma_ctrl #(
    .DMA_REG_ADDR (16'h4014),
    .OAM_DATA_ADDR(16'h2004),
    .XFER_LEN     (256)
  ) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .cpu_addr  (cpu_addr),
    .cpu_rw    (cpu_rw),
    .cpu_wdata (cpu_wdata),
    .bus_rdata (bus_rdata),
    .cpu_halt  (cpu_halt),
    .dma_active(dma_active),
    .dma_addr  (dma_addr),
    .dma_rw    (dma_rw),
    .dma_wdata (dma_wdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus_rdata = mem[dma_addr];

  function automatic op_t mk_op(input logic [15:0] a, input logic rw, input logic [7:0] d);
    op_t o;
    o.addr = a;
    o.rw   = rw;
    o.data = d;
    return o;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_cnt++;
  endtask

  task automatic idle_bus();
    cpu_rw    = 1'b1;
    cpu_addr  = 16'h0000;
    cpu_wdata = 8'h00;
  endtask

  // want_par: parity of the HALT cycle (0/1), or 2 to trigger right away.
  task automatic do_dma(input logic [7:0] pg, input int want_par, input bit retrig,
                        input bit late_wr, input string tag);
    int  hp;
    int  halted;
    int  exp_len;
    int  mism;
    op_t got[$];
    op_t exp[$];
    if (want_par != 2)
      while (((edge_cnt + 1) % 2) != want_par) tick();
    hp = (edge_cnt + 1) % 2;
    // Reference: optional dummy read, then read/put pairs for the whole page.
    if (hp == 1) exp.push_back(mk_op({pg, 8'h00}, 1'b1, 8'h00));
    for (int i = 0; i < 256; i++) begin
      exp.push_back(mk_op({pg, 8'(i)}, 1'b1, 8'h00));
      exp.push_back(mk_op(16'h2004, 1'b0, mem[{pg, 8'(i)}]));
    end
    exp_len = 513 + hp;
    cpu_rw    = 1'b0;
    cpu_addr  = 16'h4014;
    cpu_wdata = pg;
    tick();
    check({tag, "_halt_entry"}, {30'd0, cpu_halt, dma_active}, 32'b10);
    idle_bus();
    halted = 0;
    for (int c = 0; c < 600 && cpu_halt; c++) begin
      halted++;
      if (dma_active)
        got.push_back(mk_op(dma_addr, dma_rw, dma_rw ? 8'h00 : dma_wdata));
      if (retrig) begin
        if (c >= 5 && c < 200) begin
          cpu_rw = 1'b0; cpu_addr = 16'h4014; cpu_wdata = 8'h07;
        end else idle_bus();
      end
      if (late_wr && halted == exp_len) begin
        cpu_rw = 1'b0; cpu_addr = 16'h4014; cpu_wdata = 8'h33;
      end
      tick();
    end
    check({tag, "_halt_len"}, 32'(halted), 32'(exp_len));
    check({tag, "_ops"}, 32'(got.size()), 32'(exp.size()));
    mism = 0;
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      if (got[i] !== exp[i]) mism++;
    check({tag, "_seq_mism"}, 32'(mism), 32'd0);
    check({tag, "_release"}, {29'd0, busy, dma_active, dma_rw}, 32'b001);
    if (late_wr) begin
      idle_bus();
      tick();
      check({tag, "_late_wr_busy"}, {31'd0, busy}, 32'd0);
    end
    idle_bus();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    edge_cnt = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;
    idle_bus();
    n_reset = 1'b0;
    #1;
    check("reset_outs", {cpu_halt, dma_active, dma_rw, busy}, 32'b0010);
    check("reset_addr", {8'd0, dma_wdata, dma_addr}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    n_reset  = 1'b1;
    edge_cnt = 0;

    // Even and odd aligned transfers from page $02.
    do_dma(8'h02, 0, 1'b0, 1'b0, "even");
    do_dma(8'h02, 1, 1'b0, 1'b0, "odd");

    // Reset in the middle of a transfer, then restart from idx 0.
    cpu_rw = 1'b0; cpu_addr = 16'h4014; cpu_wdata = 8'h02;
    tick();
    idle_bus();
    repeat (100) tick();
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    #2;
    n_reset = 1'b0;
    #1;
    check("midreset_outs", {cpu_halt, dma_active, dma_rw, busy}, 32'b0010);
    check("midreset_addr", {16'd0, dma_addr}, 32'd0);
    @(posedge clk);
    #1;
    n_reset  = 1'b1;
    edge_cnt = 0;
    do_dma(8'h02, int'($urandom_range(0, 1)), 1'b0, 1'b0, "restart");

    // Retrigger attempts during a transfer are ignored.
    do_dma(8'h02, 0, 1'b1, 1'b0, "retrig");

    // Non-trigger accesses.
    cpu_rw = 1'b1; cpu_addr = 16'h4014; cpu_wdata = 8'h02;
    tick();
    check("read4014_busy", {31'd0, busy}, 32'd0);
    cpu_rw = 1'b0; cpu_addr = 16'h4015; cpu_wdata = 8'h02;
    tick();
    check("write4015_busy", {31'd0, busy}, 32'd0);
    check("idle_bus", {15'd0, dma_rw, dma_addr}, {15'd0, 1'b1, 16'h0000});
    idle_bus();
    tick();
    do_dma(8'hFF, 1, 1'b0, 1'b0, "pageff");
    do_dma(8'h20, 0, 1'b0, 1'b0, "page20");

    // Write landing on the release edge is not detected.
    do_dma(8'(($urandom_range(0, 254))), 1, 1'b0, 1'b1, "late");

    // Back-to-back triggers one cycle after release.
    do_dma(8'h02, 0, 1'b0, 1'b0, "b2b0");
    do_dma(8'h02, 2, 1'b0, 1'b0, "b2b1");
    do_dma(8'($urandom), 2, 1'b0, 1'b0, "b2b2");

    // Random pages and alignment.
    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(0, 5)) tick();
      do_dma(8'($urandom), int'($urandom_range(0, 1)), 1'b0, 1'b0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
